// File: rtl/tick_period_mon_if.sv
// Tick period monitor bus: tick/clear in, measured statistics out.
// Optional TPM_AVG_EN adds the averaging-window sum outputs.
interface tpm_if #(
  parameter int CNT_W = 8
);
  logic             tick_in;
  logic             clr;
  logic [CNT_W-1:0] period_last;
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;
  logic             period_vld;
  logic [15:0]      tick_count;
  logic             err_timeout;
`ifdef TPM_AVG_EN
  logic [CNT_W+7:0] period_sum;
  logic             sum_vld;

  modport master (
    output tick_in, clr,
    input  period_last, period_min, period_max,
    input  period_vld, tick_count, err_timeout,
    input  period_sum, sum_vld
  );
  modport slave (
    input  tick_in, clr,
    output period_last, period_min, period_max,
    output period_vld, tick_count, err_timeout,
    output period_sum, sum_vld
  );
`else
  modport master (
    output tick_in, clr,
    input  period_last, period_min, period_max,
    input  period_vld, tick_count, err_timeout
  );
  modport slave (
    input  tick_in, clr,
    output period_last, period_min, period_max,
    output period_vld, tick_count, err_timeout
  );
`endif
endinterface

// File: rtl/tick_period_mon.sv
// Measures intervals between tick pulses, tracks min/max/count, flags loss.
// Define TPM_AVG_EN to add a summed window of AVG_N intervals.
module tick_period_mon #(
  parameter int CNT_W      = 8,
  parameter int MAX_PERIOD = 200,
  parameter int AVG_N      = 10
) (
  input  logic  clk,
  input  logic  rst_n,
  tpm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOST
  } state_e;

  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONES = '1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_q;
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] max_q;
  logic             vld_q;
  logic [15:0]      tcnt_q;
  logic             err_q;

  logic [CNT_W-1:0] min_d;
  logic [CNT_W-1:0] max_d;
  logic [15:0]      tcnt_d;
  logic             meas;
  logic             tmo;

  assign min_d  = (cnt_q < min_q) ? cnt_q : min_q;
  assign max_d  = (cnt_q > max_q) ? cnt_q : max_q;
  assign tcnt_d = (tcnt_q == 16'hFFFF) ? tcnt_q
                                       : tcnt_q + 16'd1;

  assign meas = !bus.clr && state_q == ARMED
             && bus.tick_in;
  assign tmo  = !bus.clr && state_q == ARMED
             && !bus.tick_in && cnt_q == MAXP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      min_q   <= ONES;
      max_q   <= '0;
      vld_q   <= 1'b0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.clr) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        last_q  <= '0;
        min_q   <= ONES;
        max_q   <= '0;
        tcnt_q  <= '0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.tick_in) begin
              state_q <= ARMED;
              cnt_q   <= ONE;
            end
          end
          ARMED: begin
            if (bus.tick_in) begin
              last_q <= cnt_q;
              min_q  <= min_d;
              max_q  <= max_d;
              tcnt_q <= tcnt_d;
              vld_q  <= 1'b1;
              cnt_q  <= ONE;
            end else if (cnt_q == MAXP) begin
              // cnt holds so the stalled count stays observable
              state_q <= LOST;
              err_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
          LOST: begin
            if (bus.tick_in) begin
              state_q <= ARMED;
              cnt_q   <= ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.period_last = last_q;
  assign bus.period_min  = min_q;
  assign bus.period_max  = max_q;
  assign bus.period_vld  = vld_q;
  assign bus.tick_count  = tcnt_q;
  assign bus.err_timeout = err_q;

`ifdef TPM_AVG_EN
  localparam int WIN_W = $clog2(AVG_N) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(AVG_N - 1);

  logic [CNT_W+7:0] acc_q;
  logic [CNT_W+7:0] acc_d;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W+7:0] sum_q;
  logic             svld_q;

  assign acc_d = acc_q + {8'd0, cnt_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      win_q  <= '0;
      sum_q  <= '0;
      svld_q <= 1'b0;
    end else begin
      svld_q <= 1'b0;
      if (bus.clr) begin
        acc_q <= '0;
        win_q <= '0;
        sum_q <= '0;
      end else if (tmo) begin
        acc_q <= '0;
        win_q <= '0;
      end else if (meas) begin
        if (win_q == WIN_LAST) begin
          sum_q  <= acc_d;
          svld_q <= 1'b1;
          acc_q  <= '0;
          win_q  <= '0;
        end else begin
          acc_q <= acc_d;
          win_q <= win_q + WIN_W'(1);
        end
      end
    end
  end

  assign bus.period_sum = sum_q;
  assign bus.sum_vld    = svld_q;
`else
  logic unused_ok;
  assign unused_ok = tmo ^ meas;
`endif

endmodule

// File: tb/tb_tick_period_mon.sv
// Scoreboard bench for tick_period_mon (MAX_PERIOD=16).
// Expected measurements are queued by stimulus and popped by a monitor.
module tb_tick_period_mon;

  logic clk;
  logic rst_n;

  tpm_if #(.CNT_W(8)) bus ();

  tick_period_mon #(
    .CNT_W(8),
    .MAX_PERIOD(16),
    .AVG_N(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0]  last;
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   sq[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic step(logic t, logic c);
    bus.tick_in = t;
    bus.clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_after(int n);
    repeat (n - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic push(int l, int mn, int mx, int c);
    exp_t e;
    e.last = 8'(l);
    e.mn   = 8'(mn);
    e.mx   = 8'(mx);
    e.cnt  = 16'(c);
    q.push_back(e);
  endtask

  task automatic chk_clear(string n);
    chk({n, "_last"}, 32'(bus.period_last), 0);
    chk({n, "_min"},  32'(bus.period_min), 255);
    chk({n, "_max"},  32'(bus.period_max), 0);
    chk({n, "_cnt"},  32'(bus.tick_count), 0);
    chk({n, "_err"},  32'(bus.err_timeout), 0);
    chk({n, "_vld"},  32'(bus.period_vld), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.period_vld) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_vld: got last=%0d expected none",
                 bus.period_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("vld_last", 32'(bus.period_last), 32'(e.last));
        chk("vld_min",  32'(bus.period_min),  32'(e.mn));
        chk("vld_max",  32'(bus.period_max),  32'(e.mx));
        chk("vld_cnt",  32'(bus.tick_count),  32'(e.cnt));
      end
    end
  end

`ifdef TPM_AVG_EN
  always @(negedge clk) begin
    if (rst_n && bus.sum_vld) begin
      if (sq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sum: got %0d expected none",
                 bus.period_sum);
      end else begin
        chk("sum", 32'(bus.period_sum), 32'(sq.pop_front()));
      end
    end
  end
`endif

  int pat[8] = '{5, 5, 5, 8, 5, 5, 5, 8};

  initial begin
    rst_n       = 1'b0;
    bus.tick_in = 1'b0;
    bus.clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_clear("reset");
    rst_n = 1'b1;

    // four ticks, 5 apart
    step(1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      push(5, 5, 5, i);
      tick_after(5);
    end
    step(1'b0, 1'b0);
    chk("t1_count", 32'(bus.tick_count), 3);

    // clear, then pattern 5,5,5,8 twice
    step(1'b0, 1'b1);
    chk_clear("clr");
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      push(pat[i], 5, (i >= 3) ? 8 : 5, i + 1);
      tick_after(pat[i]);
    end
    step(1'b0, 1'b0);
    chk("t2_last", 32'(bus.period_last), 8);

    // clear wins over a simultaneous tick
    step(1'b1, 1'b1);
    chk_clear("clr_tick");
    tick_after(3);
    push(4, 4, 4, 1);
    tick_after(4);

    // timeout exactly 16 cycles after the arming tick
    repeat (15) step(1'b0, 1'b0);
    chk("tmo_before", 32'(bus.err_timeout), 0);
    step(1'b0, 1'b0);
    chk("tmo_at16", 32'(bus.err_timeout), 1);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("tmo_rearm_err", 32'(bus.err_timeout), 1);
    chk("tmo_rearm_cnt", 32'(bus.tick_count), 1);
    push(6, 4, 6, 2);
    tick_after(6);
    push(1, 1, 6, 3);
    step(1'b1, 1'b0);
    push(1, 1, 6, 4);
    step(1'b1, 1'b0);
    chk("tmo_sticky", 32'(bus.err_timeout), 1);

    // async reset mid-interval (cnt=3)
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_clear("async_rst");
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    push(7, 7, 7, 1);
    tick_after(7);

`ifdef TPM_AVG_EN
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    sq.push_back(50);
    for (int i = 1; i <= 10; i++) begin
      push(5, 5, 5, i);
      tick_after(5);
    end
`endif

    repeat (3) step(1'b0, 1'b0);
    chk("queue_drained", 32'(q.size()), 0);
    chk("sum_q_drained", 32'(sq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tick_period_mon.md
TICK_PERIOD_MON -- requirements
Module: tick_period_mon

Interface
REQ-001 Parameter CNT_W, default 8: width of interval counter and period outputs.
REQ-002 Parameter MAX_PERIOD, default 200: cycle count at which a missing tick is declared; SHALL satisfy 2 <= MAX_PERIOD <= 2^CNT_W-1.
REQ-003 Parameter AVG_N, default 10: number of intervals summed per average window (TPM_AVG_EN only).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tick_in  input  1  divided-clock pulse from the upstream fractional divider, synchronous to clk; each high cycle is one tick.
REQ-007 clr  input  1  synchronous clear of statistics and error.
REQ-008 period_last  output  CNT_W  most recent measured interval in clk cycles.
REQ-009 period_min  output  CNT_W  smallest interval since reset/clr.
REQ-010 period_max  output  CNT_W  largest interval since reset/clr.
REQ-011 period_vld  output  1  one-cycle pulse when period_last/min/max update.
REQ-012 tick_count  output  16  intervals measured since reset/clr, saturating at 16'hFFFF.
REQ-013 err_timeout  output  1  sticky flag: no tick within MAX_PERIOD cycles while armed.

Function
REQ-014 FSM states: IDLE (no reference tick), ARMED (counting since last tick), LOST (timeout occurred).
REQ-015 IDLE: tick_in=1 -> ARMED, interval counter cnt loads 1; no measurement.
REQ-016 ARMED, tick_in=0: cnt increments by 1 per cycle.
REQ-017 ARMED, tick_in=1: period_last <= cnt, period_vld=1 next cycle, cnt reloads 1; interval = cycles between the two sampled ticks (tick at cycle t and t+5 -> 5).
REQ-018 On each measurement: period_min <= min(period_min, cnt); period_max <= max(period_max, cnt); tick_count increments (saturating).
REQ-019 Output latency: all outputs registered; visible one cycle after the edge sampling the tick.
REQ-020 ARMED, tick_in=0 with cnt == MAX_PERIOD: -> LOST, err_timeout <= 1, cnt holds; no measurement.
REQ-021 LOST: tick_in=1 -> ARMED, cnt loads 1, no measurement (re-arm only); err_timeout stays 1.
REQ-022 Consecutive high tick_in cycles: each measures interval 1.
REQ-023 clr=1: state -> IDLE, cnt=0, period_min=all ones, period_max=0, period_last=0, tick_count=0, err_timeout=0, period_vld=0; clr has priority over a simultaneous tick, which is discarded.

Reset
REQ-024 rst_n low asynchronously forces: state IDLE, cnt 0, period_last 0, period_min all ones, period_max 0, period_vld 0, tick_count 0, err_timeout 0 (and avg outputs 0).
REQ-025 Reset asserted mid-interval discards the partial interval; first tick after release only arms.

Configuration
REQ-026 Macro TPM_AVG_EN defined: adds outputs period_sum [CNT_W+7:0] and sum_vld [1]; each measurement adds cnt to an accumulator; after AVG_N measurements period_sum <= total, sum_vld pulses one cycle, accumulator restarts at 0; clr, timeout and reset clear the accumulator and window count.
REQ-027 TPM_AVG_EN undefined: period_sum, sum_vld ports and accumulator logic absent; all other behaviour identical.

Verification
REQ-028 Ticks every 5 cycles, 4 ticks -> 3 period_vld pulses, period_last=min=max=5, tick_count=3.
REQ-029 Repeating interval pattern 5,5,5,8 from upstream divider -> period_min=5, period_max=8, period_last follows pattern with 1-cycle latency.
REQ-030 MAX_PERIOD=16, one tick then silence -> err_timeout rises exactly 16 cycles after arming tick; next tick re-arms, no period_vld.
REQ-031 clr and tick_in high in same cycle after stats built -> all stats at clear values, state IDLE, following tick only arms.
REQ-032 rst_n pulsed low mid-interval (cnt=3) -> outputs at reset values immediately; resumed ticks every 7 -> first period_vld reports 7 on second tick.
REQ-033 TPM_AVG_EN, AVG_N=10, ticks every 5 for 11 ticks -> single sum_vld with period_sum=50.
